// File: rtl/board_scanner.sv
// board_scanner
//   Reads the whole tetris board out of the core one cell per cycle, in raster
//   order with x varying fastest. The cells go into the back half of a
//   double-buffered shadow board. When the last cell has been captured, the two
//   halves swap and the renderer sees the new frame. Score, hold and the next
//   queue are latched when the snapshot starts and are published at the swap,
//   so the sidebar always matches the board that is on display.
//
// Ports
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   start                   single-cycle snapshot request (ignored while busy)
//   q_x, q_y / q_kind       query address to the core / kind returned LAT cycles later
//   score_in, hold_in,
//   next_in                 core sidebar state, captured when start is accepted
//   rd_x, rd_y / rd_kind    renderer read port on the front buffer (one cycle latency)
//   score_out, hold_out,
//   next_out                sidebar of the frame currently in front
//   busy                    snapshot in progress, up to and including the done cycle
//   done                    one-cycle pulse in the cycle the new frame is published
module board_scanner #(
  parameter int COLS = 10,
  parameter int ROWS = 20,
  parameter int LAT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [3:0]  q_x,
  output logic [4:0]  q_y,
  input  logic [2:0]  q_kind,
  input  logic [15:0] score_in,
  input  logic [2:0]  hold_in,
  input  logic [11:0] next_in,
  input  logic [3:0]  rd_x,
  input  logic [4:0]  rd_y,
  output logic [2:0]  rd_kind,
  output logic [15:0] score_out,
  output logic [2:0]  hold_out,
  output logic [11:0] next_out,
  output logic        busy,
  output logic        done
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(2 * CELLS);
  // The pipe keeps at least one stage so the array is never zero-sized.
  // With LAT=0 that stage is simply not used.
  localparam int PD    = (LAT > 0) ? LAT : 1;

  localparam logic [3:0] X_LAST     = 4'(COLS - 1);
  localparam logic [4:0] Y_LAST     = 5'(ROWS - 1);
  localparam logic [3:0] X_LIM      = 4'(COLS);
  localparam logic [4:0] Y_LIM      = 5'(ROWS);
  localparam logic [1:0] DRAIN_LAST = 2'((LAT > 1) ? LAT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_SWAP} state_t;

  typedef struct packed {
    logic       v;
    logic [4:0] y;
    logic [3:0] x;
  } cap_t;

  state_t      state_q, state_d;
  logic [3:0]  x_q;
  logic [4:0]  y_q;
  logic [1:0]  drain_q;
  logic        front_q;
  logic        valid_q;
  logic [15:0] score_pend_q;
  logic [2:0]  hold_pend_q;
  logic [11:0] next_pend_q;
  logic [15:0] score_q;
  logic [2:0]  hold_q;
  logic [11:0] next_q;
  logic        rd_ok_q;
  logic [2:0]  rd_data_q;
  cap_t        pipe_q [PD];
  cap_t        stage0;
  cap_t        wr;
  logic        last_addr;
  logic        rd_in_range;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  // Two frames stored back to back. The front select chooses which half the
  // renderer reads. The scanner always writes the other half.
  logic [2:0] buf_mem [0:2*CELLS-1];

  function automatic logic [AW-1:0] cell_addr(input logic bank, input logic [4:0] y,
                                              input logic [3:0] x);
    logic [AW-1:0] base;
    base = bank ? AW'(CELLS) : '0;
    return base + AW'(y) * AW'(COLS) + AW'(x);
  endfunction

  assign last_addr = (x_q == X_LAST) && (y_q == Y_LAST);

  // The address issued in the current cycle. The pipe delays it by LAT cycles
  // so that it lines up with the kind the core returns for it.
  assign stage0 = '{v: (state_q == S_SCAN), y: y_q, x: x_q};
  assign wr     = (LAT == 0) ? stage0 : pipe_q[PD-1];

  assign wr_addr     = cell_addr(~front_q, wr.y, wr.x);
  assign rd_in_range = (rd_x < X_LIM) && (rd_y < Y_LIM);
  // An out-of-range address is clamped so the RAM is never indexed past its end.
  // The returned data is masked to 0 in that case anyway.
  assign rd_addr     = rd_in_range ? cell_addr(front_q, rd_y, rd_x) : '0;

  // State register and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      drain_q      <= '0;
      front_q      <= 1'b0;
      valid_q      <= 1'b0;
      score_pend_q <= '0;
      hold_pend_q  <= '0;
      next_pend_q  <= '0;
      score_q      <= '0;
      hold_q       <= '0;
      next_q       <= '0;
      rd_ok_q      <= 1'b0;
      for (int i = 0; i < PD; i++) pipe_q[i] <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == S_SCAN && !last_addr) begin
        if (x_q == X_LAST) begin
          x_q <= '0;
          y_q <= y_q + 5'd1;
        end else begin
          x_q <= x_q + 4'd1;
        end
      end else begin
        x_q <= '0;
        y_q <= '0;
      end

      drain_q <= (state_q == S_DRAIN) ? drain_q + 2'd1 : 2'd0;

      if (state_q == S_IDLE && start) begin
        score_pend_q <= score_in;
        hold_pend_q  <= hold_in;
        next_pend_q  <= next_in;
      end

      if (state_q == S_SWAP) begin
        front_q <= ~front_q;
        valid_q <= 1'b1;
        score_q <= score_pend_q;
        hold_q  <= hold_pend_q;
        next_q  <= next_pend_q;
      end

      pipe_q[0] <= stage0;
      for (int i = 1; i < PD; i++) pipe_q[i] <= pipe_q[i-1];

      rd_ok_q <= valid_q && rd_in_range;
    end
  end

  // Block RAM: one write port for the capture path and one registered read
  // port for the renderer.
  always_ff @(posedge clk) begin
    if (wr.v) buf_mem[wr_addr] <= q_kind;
  end

  always_ff @(posedge clk) begin
    rd_data_q <= buf_mem[rd_addr];
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SCAN;
      S_SCAN:  if (last_addr) state_d = (LAT == 0) ? S_SWAP : S_DRAIN;
      S_DRAIN: if (drain_q == DRAIN_LAST) state_d = S_SWAP;
      S_SWAP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_SWAP);
    q_x       = (state_q == S_SCAN) ? x_q : 4'd0;
    q_y       = (state_q == S_SCAN) ? y_q : 5'd0;
    rd_kind   = rd_ok_q ? rd_data_q : 3'd0;
    score_out = score_q;
    hold_out  = hold_q;
    next_out  = next_q;
  end

endmodule

// File: tb/tb_board_scanner.sv
module tb_board_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  q_x;
  logic [4:0]  q_y;
  logic [2:0]  q_kind = 3'd0;
  logic [15:0] score_in;
  logic [2:0]  hold_in;
  logic [11:0] next_in;
  logic [3:0]  rd_x;
  logic [4:0]  rd_y;
  logic [2:0]  rd_kind;
  logic [15:0] score_out;
  logic [2:0]  hold_out;
  logic [11:0] next_out;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  int done_total = 0;
  int mode = 0;
  int d0;

  always #5 clk = ~clk;

  board_scanner #(.COLS(10), .ROWS(20), .LAT(1)) dut (
    .clk(clk), .reset(reset), .start(start),
    .q_x(q_x), .q_y(q_y), .q_kind(q_kind),
    .score_in(score_in), .hold_in(hold_in), .next_in(next_in),
    .rd_x(rd_x), .rd_y(rd_y), .rd_kind(rd_kind),
    .score_out(score_out), .hold_out(hold_out), .next_out(next_out),
    .busy(busy), .done(done)
  );

  // Core model with one cycle of latency: mode 0 returns (x+y)%8,
  // mode 1 returns 2 everywhere, mode 2 returns 5 everywhere.
  function automatic logic [2:0] kind_of(input logic [3:0] x, input logic [4:0] y);
    int s;
    s = int'(x) + int'(y);
    case (mode)
      0: return 3'(s % 8);
      1: return 3'd2;
      default: return 3'd5;
    endcase
  endfunction

  always @(posedge clk) q_kind <= kind_of(q_x, q_y);

  always @(posedge clk) begin
    if (done === 1'b1) done_total <= done_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input string tag, input logic [3:0] x, input logic [4:0] y,
                          input logic [2:0] exp);
    rd_x = x;
    rd_y = y;
    tick();
    check(tag, rd_kind, exp);
  endtask

  // Issues a start and follows the scan to its done cycle. The task returns
  // while the done pulse is still high.
  // With chk_seq set, it checks every query address and the frozen sidebar.
  // It also raises a second start in the middle of the scan, which must be ignored.
  task automatic run_scan(input bit chk_seq, input logic [15:0] score_late);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (chk_seq) begin
        check("q_addr", {q_y, q_x}, {5'(k / 10), 4'(k % 10)});
        if (k == 150) check("score_mid", score_out, 32'h0);
      end
      if (k == 10) score_in = score_late;
      start = chk_seq && (k == 49);
      tick();
    end
    start = 1'b0;
    check("drain_done", done, 1'b0);
    check("drain_busy", busy, 1'b1);
    check("drain_q", {q_y, q_x}, 32'h0);
    tick();
    check("swap_done", done, 1'b1);
    check("swap_busy", busy, 1'b1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rd_x = 4'd3; rd_y = 5'd5;
    score_in = '0; hold_in = '0; next_in = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state and idle behaviour
    check("rst_rd_kind", rd_kind, 3'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_q", {q_y, q_x}, 32'h0);
    check("rst_done", done, 1'b0);
    check("rst_score", score_out, 16'h0);
    check("rst_hold", hold_out, 3'd0);
    check("rst_next", next_out, 12'h0);
    d0 = done_total;
    repeat (500) tick();
    check("idle_no_done", done_total - d0, 0);
    check("idle_rd_kind", rd_kind, 3'd0);

    // First frame: address sequence, latency, sidebar, and start ignored while busy
    mode = 0;
    score_in = 16'h0123; hold_in = 3'd6; next_in = 12'h5a3;
    d0 = done_total;
    run_scan(1'b1, 16'h0456);
    check("done_cyc_score", score_out, 16'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("post_busy", busy, 1'b0);
    check("post_done", done, 1'b0);
    check("post_score", score_out, 16'h0123);
    check("post_hold", hold_out, 3'd6);
    check("post_next", next_out, 12'h5a3);
    repeat (5) tick();
    check("ignored_busy", busy, 1'b0);
    check("one_done", done_total - d0, 1);

    rd_check("rd_9_19", 4'd9, 5'd19, 3'd4);
    rd_check("rd_3_2", 4'd3, 5'd2, 3'd5);
    rd_check("rd_7_0", 4'd7, 5'd0, 3'd7);
    rd_check("rd_0_0", 4'd0, 5'd0, 3'd0);
    rd_check("rd_x_oob", 4'd10, 5'd3, 3'd0);
    rd_check("rd_y_oob", 4'd2, 5'd20, 3'd0);
    rd_check("rd_both_oob", 4'd15, 5'd31, 3'd0);

    // Double buffer: frame A all 2, then frame B all 5 with (0,0) polled
    mode = 1;
    run_scan(1'b0, 16'h0123);
    tick();
    mode = 2;
    rd_check("db_before", 4'd0, 5'd0, 3'd2);
    run_scan(1'b0, 16'h0123);
    check("db_done_cyc", rd_kind, 3'd2);
    tick();
    check("db_after_done", rd_kind, 3'd2);
    tick();
    check("db_new_front", rd_kind, 3'd5);
    rd_check("db_9_19", 4'd9, 5'd19, 3'd5);

    // Reset in the middle of a scan
    mode = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (99) tick();
    check("mid_busy_pre", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("mrst_busy", busy, 1'b0);
    check("mrst_q", {q_y, q_x}, 32'h0);
    check("mrst_rd_kind", rd_kind, 3'd0);
    check("mrst_score", score_out, 16'h0);
    check("mrst_done", done, 1'b0);
    d0 = done_total;
    repeat (3) tick();
    reset = 1'b0;
    rd_x = 4'd9; rd_y = 5'd19;
    repeat (300) tick();
    check("mrst_no_done", done_total - d0, 0);
    check("mrst_rd_invalid", rd_kind, 3'd0);

    score_in = 16'h0789; hold_in = 3'd1; next_in = 12'h111;
    run_scan(1'b1, 16'h0789);
    tick();
    check("rescan_score", score_out, 16'h0789);
    check("rescan_rd_swapcyc", rd_kind, 3'd0);
    tick();
    check("rescan_rd_9_19", rd_kind, 3'd4);
    check("rescan_one_done", done_total - d0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
